ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute stage of the 5-stage pipeline: ID/EX register, ALU datapath, EX/MEM register.
- Consumes the ALU operation code (ALUCtrl, 5 bits) and Sign bit produced by the decode-stage ALU control, together with operands and control from ID.
- Drives registered result, flags and control to the MEM stage.
- Stall and flush inputs come from the hazard unit.

Parameters:
- WIDTH, 32, datapath width.
- REG_BITS, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_alu_ctrl  in  5  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT.
- id_sign  in  1  signed-op select.
- id_a  in  WIDTH  operand A (rs or forwarded value).
- id_b  in  WIDTH  operand B (rt or immediate).
- id_shamt  in  5  shift amount.
- id_store_data  in  WIDTH  rt value for stores.
- id_rd  in  REG_BITS  destination register.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control.
- stall  in  1  hold ID/EX, bubble EX/MEM.
- flush  in  1  squash the instruction entering ID/EX.
- ex_valid  out  1  EX/MEM slot valid.
- ex_result  out  WIDTH  ALU result.
- ex_zero  out  1  result == 0.
- ex_overflow  out  1  signed ADD/SUB overflow.
- ex_store_data  out  WIDTH  pass-through.
- ex_rd  out  REG_BITS  pass-through.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  gated control.

Behaviour:
- Reset (synchronous): every ID/EX field and every ex_* output goes to 0. Reset overrides stall and flush.
- ID/EX register update per edge:
  - flush = 1: load a bubble (valid = 0, all control 0, data 0). Flush wins over stall.
  - stall = 1 and flush = 0: hold the current contents.
  - Otherwise: capture all id_* inputs.
- ALU (combinational on ID/EX contents):
  - ADD / SUB: a+b / a−b, mod 2^WIDTH.
  - AND / OR / XOR / NOR: bitwise.
  - SLL: b << shamt. SRL: b >> shamt, logical. SRA: b >>> shamt, arithmetic. Shift amount is 0..31.
  - SLT: 1 if a < b, else 0. Signed compare when sign = 1, unsigned when sign = 0.
  - ctrl 10..31: result 0, overflow 0.
- Overflow:
  - ADD: set only when sign = 1 and both operands have equal MSBs that differ from the result MSB.
  - SUB: set only when sign = 1 and the operand MSBs differ and the result MSB differs from a's MSB.
  - All other ops, or sign = 0: 0.
- EX/MEM register update per edge:
  - stall = 1: load a bubble (valid = 0, reg_write/mem_read/mem_write = 0, data 0).
  - Otherwise: load the ALU outputs plus the pass-throughs.
  - Control outputs are ANDed with the ID/EX valid bit, so a bubble never writes.
- Flush does not affect an EX/MEM load in the same cycle.
- Latency: an instruction captured at edge N shows on ex_* after edge N+1, i.e. 2 edges with no stall.
- Each stall cycle adds exactly one bubble and loses no instruction.
- Back-to-back issue: one instruction per cycle throughput.
- Reset mid-stall: all state cleared. The first instruction after reset is captured normally.

Test Plan:
- Reset, then ADD sign=1, a=7, b=5 → two edges later ex_result=12, ex_valid=1, ex_zero=0, ex_overflow=0.
- ADD sign=1, a=0x7FFFFFFF, b=1 → ex_result=0x80000000, ex_overflow=1. Repeat with sign=0 → ex_overflow=0.
- SLT with a=0xFFFFFFFF, b=1: sign=1 → ex_result=1; sign=0 → ex_result=0. SUB a=b=9 → ex_zero=1.
- SRA b=0x80000000 shamt=4 → 0xF8000000. SRL same → 0x08000000. SLL b=1 shamt=31 → 0x80000000.
- Issue I1, I2, I3 back-to-back and assert stall for 2 cycles while I2 is in ID/EX:
  - ex outputs show I1, bubble, bubble, I2, I3.
  - During bubbles ex_valid=0 and ex_reg_write=0.
- Assert flush and stall together while I2 is on id_* → I2 never reaches ex_* (ex_valid stays 0 for its slot). Assert reset during a stall → all ex_* outputs 0 on the next edge.

Source files
------------

// File: rtl/ex_alu_stage.sv
// ex_alu_stage
// Execute stage of the 5-stage pipeline: ID/EX register, ALU datapath and
// EX/MEM register.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   id_*                instruction fields and control from the decode stage
//   stall               hold ID/EX, insert a bubble into EX/MEM
//   flush               squash the instruction entering ID/EX
//   ex_*                registered ALU result, flags and control for MEM
module ex_alu_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [4:0]          id_alu_ctrl,
  input  logic                id_sign,
  input  logic [WIDTH-1:0]    id_a,
  input  logic [WIDTH-1:0]    id_b,
  input  logic [4:0]          id_shamt,
  input  logic [WIDTH-1:0]    id_store_data,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [WIDTH-1:0]    ex_result,
  output logic                ex_zero,
  output logic                ex_overflow,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write
);

  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOR = 5'd5;
  localparam logic [4:0] OP_SLL = 5'd6;
  localparam logic [4:0] OP_SRL = 5'd7;
  localparam logic [4:0] OP_SRA = 5'd8;
  localparam logic [4:0] OP_SLT = 5'd9;

  logic                r_valid;
  logic [4:0]          r_ctrl;
  logic                r_sign;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [4:0]          r_shamt;
  logic [WIDTH-1:0]    r_store_data;
  logic [REG_BITS-1:0] r_rd;
  logic                r_reg_write;
  logic                r_mem_read;
  logic                r_mem_write;

  logic [WIDTH-1:0]    w_sum;
  logic [WIDTH-1:0]    w_diff;
  logic                w_lt;
  logic [WIDTH-1:0]    w_result;
  logic                w_overflow;

  // ID/EX: flush takes priority over stall so a squashed slot never lingers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_sign       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_shamt      <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_ctrl       <= id_alu_ctrl;
      r_sign       <= id_sign;
      r_a          <= id_a;
      r_b          <= id_b;
      r_shamt      <= id_shamt;
      r_store_data <= id_store_data;
      r_rd         <= id_rd;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
    end
  end

  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;
  assign w_lt   = r_sign ? ($signed(r_a) < $signed(r_b)) : (r_a < r_b);

  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    case (r_ctrl)
      OP_ADD: begin
        w_result   = w_sum;
        // Like-signed operands producing a result of the other sign.
        w_overflow = r_sign & (r_a[MSB] == r_b[MSB]) & (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_result   = w_diff;
        w_overflow = r_sign & (r_a[MSB] != r_b[MSB]) & (w_diff[MSB] != r_a[MSB]);
      end
      OP_AND: w_result = r_a & r_b;
      OP_OR:  w_result = r_a | r_b;
      OP_XOR: w_result = r_a ^ r_b;
      OP_NOR: w_result = ~(r_a | r_b);
      OP_SLL: w_result = r_b << r_shamt;
      OP_SRL: w_result = r_b >> r_shamt;
      OP_SRA: w_result = $unsigned($signed(r_b) >>> r_shamt);
      OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
      default: begin
        w_result   = '0;
        w_overflow = 1'b0;
      end
    endcase
  end

  // EX/MEM: a stall turns this slot into a bubble while ID/EX holds.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      ex_valid      <= 1'b0;
      ex_result     <= '0;
      ex_zero       <= 1'b0;
      ex_overflow   <= 1'b0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
    end else begin
      ex_valid      <= r_valid;
      ex_result     <= w_result;
      ex_zero       <= (w_result == '0);
      ex_overflow   <= w_overflow;
      ex_store_data <= r_store_data;
      ex_rd         <= r_rd;
      ex_reg_write  <= r_reg_write & r_valid;
      ex_mem_read   <= r_mem_read  & r_valid;
      ex_mem_write  <= r_mem_write & r_valid;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_alu_ctrl;
  logic        id_sign;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [4:0]  id_shamt;
  logic [31:0] id_store_data;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic        ex_zero;
  logic        ex_overflow;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;

  int n_checks = 0;
  int n_errors = 0;

  ex_alu_stage #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl), .id_sign(id_sign),
    .id_a(id_a), .id_b(id_b), .id_shamt(id_shamt),
    .id_store_data(id_store_data), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  ctrl;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } instr_t;

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exout_t;

  instr_t m_idex;
  exout_t m_ex;

  // Reference ALU from the arithmetic definition of each operation.
  task automatic ref_alu(input instr_t x, output logic [31:0] r, output logic o);
    longint la, lb, lr;
    la = longint'($signed(x.a));
    lb = longint'($signed(x.b));
    r = 32'd0;
    o = 1'b0;
    case (x.ctrl)
      5'd0: begin lr = la + lb; r = lr[31:0]; o = x.sign && (lr > 64'sd2147483647 || lr < -64'sd2147483648); end
      5'd1: begin lr = la - lb; r = lr[31:0]; o = x.sign && (lr > 64'sd2147483647 || lr < -64'sd2147483648); end
      5'd2: r = x.a & x.b;
      5'd3: r = x.a | x.b;
      5'd4: r = x.a ^ x.b;
      5'd5: r = ~(x.a | x.b);
      5'd6: r = x.b << x.sh;
      5'd7: r = x.b >> x.sh;
      5'd8: r = x.b[31] ? ~((~x.b) >> x.sh) : (x.b >> x.sh);
      5'd9: r = (x.sign ? (la < lb) : (x.a < x.b)) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; o = 1'b0; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    instr_t in;
    exout_t nx;
    logic [31:0] r;
    logic o;
    @(posedge clk);
    in.valid = id_valid; in.ctrl = id_alu_ctrl; in.sign = id_sign;
    in.a = id_a; in.b = id_b; in.sh = id_shamt; in.sd = id_store_data;
    in.rd = id_rd; in.rw = id_reg_write; in.mr = id_mem_read; in.mw = id_mem_write;
    nx = '{default: '0};
    if (!reset && !stall) begin
      ref_alu(m_idex, r, o);
      nx.valid = m_idex.valid; nx.result = r; nx.zero = (r == 32'd0); nx.ovf = o;
      nx.sd = m_idex.sd; nx.rd = m_idex.rd;
      nx.rw = m_idex.rw && m_idex.valid;
      nx.mr = m_idex.mr && m_idex.valid;
      nx.mw = m_idex.mw && m_idex.valid;
    end
    m_ex = nx;
    if (reset || flush) m_idex = '{default: '0};
    else if (!stall)    m_idex = in;
    #1;
    check("valid",     ex_valid,      m_ex.valid);
    check("result",    ex_result,     m_ex.result);
    check("zero",      ex_zero,       m_ex.zero);
    check("overflow",  ex_overflow,   m_ex.ovf);
    check("store",     ex_store_data, m_ex.sd);
    check("rd",        ex_rd,         m_ex.rd);
    check("reg_write", ex_reg_write,  m_ex.rw);
    check("mem_read",  ex_mem_read,   m_ex.mr);
    check("mem_write", ex_mem_write,  m_ex.mw);
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [4:0] rd);
    id_valid = v; id_alu_ctrl = c; id_sign = s; id_a = a; id_b = b; id_shamt = sh;
    id_store_data = a ^ 32'h5A5A_0000; id_rd = rd;
    id_reg_write = v; id_mem_read = 1'b0; id_mem_write = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
    id_store_data = 32'd0; id_reg_write = 1'b0;
  endtask

  // Issue one op, let it drain, compare against fixed expected values.
  task automatic run_op(input string tag, input logic [4:0] c, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_r, input logic exp_o);
    drive(1'b1, c, s, a, b, sh, 5'd3);
    tick();
    idle();
    tick();
    check({tag, "_valid"}, ex_valid, 32'd1);
    check({tag, "_res"},   ex_result, exp_r);
    check({tag, "_ovf"},   ex_overflow, exp_o);
    check({tag, "_zero"},  ex_zero, (exp_r == 32'd0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_idex = '{default: '0};
    m_ex   = '{default: '0};
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick();
    tick();
    check("rst_valid", ex_valid, 32'd0);
    check("rst_result", ex_result, 32'd0);
    reset = 1'b0;

    run_op("add7_5",    5'd0, 1'b1, 32'd7,         32'd5, 5'd0, 32'd12,        1'b0);
    run_op("add_ovf_s", 5'd0, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1);
    run_op("add_ovf_u", 5'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0);
    run_op("slt_s",     5'd9, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1,         1'b0);
    run_op("slt_u",     5'd9, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0,         1'b0);
    run_op("sub_eq",    5'd1, 1'b1, 32'd9,         32'd9, 5'd0, 32'd0,         1'b0);
    run_op("sra",       5'd8, 1'b0, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    run_op("srl",       5'd7, 1'b0, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    run_op("sll",       5'd6, 1'b0, 32'd0, 32'd1,        5'd31, 32'h8000_0000, 1'b0);
    run_op("sub_ovf",   5'd1, 1'b1, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1);
    run_op("bad_op",    5'd12, 1'b1, 32'd3,        32'd4, 5'd0, 32'd0,         1'b0);

    // I1, I2, I3 back-to-back with a two-cycle stall while I2 sits in ID/EX.
    drive(1'b1, 5'd0, 1'b1, 32'd100, 32'd1, 5'd0, 5'd11); tick();
    drive(1'b1, 5'd0, 1'b1, 32'd200, 32'd2, 5'd0, 5'd12); tick();
    check("seq_i1_rd", ex_rd, 32'd11);
    check("seq_i1_v",  ex_valid, 32'd1);
    drive(1'b1, 5'd0, 1'b1, 32'd300, 32'd3, 5'd0, 5'd13);
    stall = 1'b1;
    tick();
    check("seq_b1_v",  ex_valid, 32'd0);
    check("seq_b1_rw", ex_reg_write, 32'd0);
    tick();
    check("seq_b2_v",  ex_valid, 32'd0);
    check("seq_b2_rw", ex_reg_write, 32'd0);
    stall = 1'b0;
    tick();
    check("seq_i2_rd",  ex_rd, 32'd12);
    check("seq_i2_res", ex_result, 32'd202);
    idle();
    tick();
    check("seq_i3_rd",  ex_rd, 32'd13);
    check("seq_i3_res", ex_result, 32'd303);
    tick();

    // Flush together with stall while I2 is on the ID inputs.
    drive(1'b1, 5'd3, 1'b0, 32'hF0, 32'h0F, 5'd0, 5'd21); tick();
    drive(1'b1, 5'd4, 1'b0, 32'hAA, 32'h55, 5'd0, 5'd22);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    idle();
    tick();
    check("flush_slot_v", ex_valid, 32'd0);
    tick();
    check("flush_after_v", ex_valid, 32'd0);

    // Reset in the middle of a stall, then restart.
    drive(1'b1, 5'd0, 1'b1, 32'd40, 32'd2, 5'd0, 5'd7); tick();
    stall = 1'b1; tick();
    reset = 1'b1; tick();
    check("rst_stall_v",   ex_valid, 32'd0);
    check("rst_stall_res", ex_result, 32'd0);
    check("rst_stall_rd",  ex_rd, 32'd0);
    reset = 1'b0; stall = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'd50, 32'd8, 5'd0, 5'd9); tick();
    idle(); tick();
    check("post_rst_v",   ex_valid, 32'd1);
    check("post_rst_res", ex_result, 32'd42);

    // Randomised traffic checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 12)), 1'($urandom),
            pick_operand(), pick_operand(), 5'($urandom), 5'($urandom));
      id_store_data = $urandom;
      id_mem_read   = 1'($urandom);
      id_mem_write  = 1'($urandom);
      id_reg_write  = 1'($urandom);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      reset = ($urandom_range(0, 99) < 2);
      tick();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
